// File: rtl/pipe_pkg.sv
// Shared constants for the instruction-fetch stage: pcsource encodings, bubble word,
// IF state encoding and a word-alignment helper.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0000;

    localparam logic [1:0] IF_FETCH = 2'd0;
    localparam logic [1:0] IF_HOLD  = 2'd1;
    localparam logic [1:0] IF_DROP  = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pipe_if_npc_mux.sv
// Combinational next-PC select over pc+4 / branch / register / jump targets.
// Redirect targets are word-aligned so the PC never carries low-order bits.
module npc_mux
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    always_comb begin
        npc = pc4;
        case (pcsource)
            PCSRC_SEQ: npc = pc4;
            PCSRC_BR:  npc = word_align(bpc);
            PCSRC_JR:  npc = word_align(rpc);
            PCSRC_J:   npc = word_align(jpc);
            default:   npc = pc4;
        endcase
    end

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and feeds
// the IF/ID register, with a one-entry hold buffer for ID stalls and drop of wrong-path responses.
module pipe_if
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = PIPE_NOP_INST
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IDinst,
    output logic [31:0] IDpc4,
    output logic        IDvalid,
    output logic [1:0]  if_state
);

    // Handshake: imem_req/imem_addr are held stable until a cycle with imem_ready=1,
    // which is the single cycle in which the request and its imem_rdata complete.
    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc4;
    logic [31:0] old_addr;
    logic        redirect;

    assign pc4      = pc + 32'd4;
    assign redirect = (pcsource != PCSRC_SEQ) && !stall;

    npc_mux u_npc_mux (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .npc      (npc)
    );

    assign imem_req  = clrn && (state != IF_HOLD);
    assign imem_addr = (state == IF_DROP) ? old_addr : pc;
    assign if_state  = state;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IF_FETCH;
            pc       <= word_align(RESET_PC);
            IDinst   <= NOP_INST;
            IDpc4    <= 32'd0;
            IDvalid  <= 1'b0;
            buf_inst <= 32'd0;
            buf_pc4  <= 32'd0;
            old_addr <= 32'd0;
        end else begin
            case (state)
                IF_FETCH: begin
                    if (redirect) begin
                        pc      <= npc;
                        IDinst  <= NOP_INST;
                        IDvalid <= 1'b0;
                        // An outstanding request must still complete before the new PC is issued.
                        if (!imem_ready) begin
                            old_addr <= pc;
                            state    <= IF_DROP;
                        end
                    end else if (imem_ready && !stall) begin
                        IDinst  <= imem_rdata;
                        IDpc4   <= pc4;
                        IDvalid <= 1'b1;
                        pc      <= pc4;
                    end else if (imem_ready) begin
                        buf_inst <= imem_rdata;
                        buf_pc4  <= pc4;
                        pc       <= pc4;
                        state    <= IF_HOLD;
                    end else if (!stall) begin
                        IDinst  <= NOP_INST;
                        IDvalid <= 1'b0;
                    end
                end
                IF_HOLD: begin
                    if (!stall) begin
                        if (redirect) begin
                            pc      <= npc;
                            IDinst  <= NOP_INST;
                            IDvalid <= 1'b0;
                        end else begin
                            IDinst  <= buf_inst;
                            IDpc4   <= buf_pc4;
                            IDvalid <= 1'b1;
                        end
                        state <= IF_FETCH;
                    end
                end
                IF_DROP: begin
                    if (redirect) begin
                        pc <= npc;
                    end
                    if (!stall) begin
                        IDinst  <= NOP_INST;
                        IDvalid <= 1'b0;
                    end
                    if (imem_ready) begin
                        state <= IF_FETCH;
                    end
                end
                default: state <= IF_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_if.sv
// Bench for pipe_if: table-driven vectors, hand sequences for stall/redirect/reset corners,
// and random traffic checked against a program-order fetch model.
module tb_pipe_if;
    import pipe_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_EXP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0;
    logic [31:0] rpc = 32'd0;
    logic [31:0] jpc = 32'd0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] IDinst;
    logic [31:0] IDpc4;
    logic        IDvalid;
    logic [1:0]  if_state;

    pipe_if #(.RESET_PC(RST_PC), .NOP_INST(NOP_EXP)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .stall      (stall),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .IDinst     (IDinst),
        .IDpc4      (IDpc4),
        .IDvalid    (IDvalid),
        .if_state   (if_state)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          delivered = 0;
    logic        special = 1'b0;
    logic        pend_wait = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] exp_q[$];
    logic [31:0] fetch_q[$];

    typedef struct {
        logic        s;
        logic [1:0]  ps;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        logic [31:0] e_addr;
        logic        e_req;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[8];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Memory image: word at byte address a is a>>2, with an optional marker word at 8.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (special && a == 32'h8) return 32'h1234_5678;
        return a >> 2;
    endfunction

    // One clock: drive inputs and memory response at negedge, check after the posedge
    // against the program-order model (exp_pc is the next instruction ID should see).
    task automatic step(input logic s, input logic [1:0] ps);
        logic        p_req, p_ready, p_valid, redir;
        logic [31:0] p_addr, p_inst, p_pc4, tgt;
        @(negedge clk);
        stall = s;
        pcsource = ps;
        if (pend_wait) begin
            check1("req_stable", imem_req, 1'b1);
            check32("addr_stable", imem_addr, pend_addr);
        end
        if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_cnt = 0;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ready = 1'b0;
            wait_cnt = 0;
        end
        p_req = imem_req;
        p_ready = imem_ready;
        p_addr = imem_addr;
        p_valid = IDvalid;
        p_inst = IDinst;
        p_pc4 = IDpc4;
        redir = (ps != 2'b00) && !s;
        case (ps)
            2'b01:   tgt = bpc;
            2'b10:   tgt = rpc;
            default: tgt = jpc;
        endcase
        tgt = tgt & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        pend_wait = p_req && !p_ready;
        pend_addr = p_addr;
        if (p_req && p_ready) fetch_q.push_back(p_addr);
        if (s) begin
            check1("hold_valid", IDvalid, p_valid);
            check32("hold_inst", IDinst, p_inst);
            check32("hold_pc4", IDpc4, p_pc4);
        end else if (redir) begin
            check1("redir_bubble", IDvalid, 1'b0);
            check32("redir_inst", IDinst, NOP_EXP);
            check32("redir_pc4", IDpc4, p_pc4);
            exp_pc = tgt;
        end else if (IDvalid) begin
            check32("deliver_inst", IDinst, mem_word(exp_pc));
            check32("deliver_pc4", IDpc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            check32("bubble_inst", IDinst, NOP_EXP);
            check32("bubble_pc4", IDpc4, p_pc4);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        imem_ready = 1'b0;
        stall = 1'b0;
        pcsource = 2'b00;
        #1;
        check1("rst_valid", IDvalid, 1'b0);
        check32("rst_inst", IDinst, NOP_EXP);
        check32("rst_pc4", IDpc4, 32'd0);
        check1("rst_req", imem_req, 1'b0);
        check32("rst_addr", imem_addr, RST_PC);
        check32("rst_state", 32'(if_state), 32'(IF_FETCH));
        @(posedge clk);
        @(posedge clk);
        #1;
        clrn = 1'b1;
        exp_pc = RST_PC;
        wait_cnt = 0;
        pend_wait = 1'b0;
        fetch_q.delete();
    endtask

    initial begin
        logic        stale_seen;
        logic [31:0] got;
        int          d0;

        tbl[0] = '{1'b0, 2'b00, 1'b1, 32'd0,    32'd4,     32'd4,     1'b1, IF_FETCH};
        tbl[1] = '{1'b0, 2'b00, 1'b1, 32'd1,    32'd8,     32'd8,     1'b1, IF_FETCH};
        tbl[2] = '{1'b0, 2'b00, 1'b1, 32'd2,    32'd12,    32'd12,    1'b1, IF_FETCH};
        tbl[3] = '{1'b0, 2'b00, 1'b1, 32'd3,    32'd16,    32'd16,    1'b1, IF_FETCH};
        tbl[4] = '{1'b1, 2'b11, 1'b1, 32'd3,    32'd16,    32'd20,    1'b0, IF_HOLD};
        tbl[5] = '{1'b1, 2'b11, 1'b1, 32'd3,    32'd16,    32'd20,    1'b0, IF_HOLD};
        tbl[6] = '{1'b0, 2'b11, 1'b0, NOP_EXP,  32'd16,    32'h40,    1'b1, IF_FETCH};
        tbl[7] = '{1'b0, 2'b00, 1'b1, 32'h10,   32'h44,    32'h44,    1'b1, IF_FETCH};

        // Zero-wait stream, then a jump requested under stall.
        lat = 0;
        jpc = 32'h40;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].ps);
            check1($sformatf("tbl%0d_valid", i), IDvalid, tbl[i].e_valid);
            check32($sformatf("tbl%0d_inst", i), IDinst, tbl[i].e_inst);
            check32($sformatf("tbl%0d_pc4", i), IDpc4, tbl[i].e_pc4);
            check32($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            check1($sformatf("tbl%0d_req", i), imem_req, tbl[i].e_req);
            check32($sformatf("tbl%0d_state", i), 32'(if_state), 32'(tbl[i].e_state));
        end

        // Two wait cycles per fetch: bubbles between words, each address fetched once.
        lat = 2;
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 12; i++) step(1'b0, 2'b00);
        check32("lat2_delivered", 32'(delivered - d0), 32'd4);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        check32("lat2_fetch_count", 32'(fetch_q.size()), 32'd4);
        while (exp_q.size() > 0) begin
            got = (fetch_q.size() > 0) ? fetch_q.pop_front() : 32'hFFFF_FFFF;
            check32("lat2_fetch_addr", got, exp_q.pop_front());
        end

        // Three-cycle stall while the marker word at pc=8 returns.
        lat = 0;
        special = 1'b1;
        do_reset();
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00);
            check32("stall_state", 32'(if_state), 32'(IF_HOLD));
            check1("stall_req", imem_req, 1'b0);
            check32("stall_inst", IDinst, 32'd1);
        end
        step(1'b0, 2'b00);
        check32("unstall_inst", IDinst, 32'h1234_5678);
        check32("unstall_pc4", IDpc4, 32'd12);
        check1("unstall_valid", IDvalid, 1'b1);
        check32("unstall_addr", imem_addr, 32'd12);
        special = 1'b0;

        // Branch while the fetch of 0x10 is pending: stale word must be dropped.
        lat = 0;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00);
        lat = 3;
        bpc = 32'h100;
        step(1'b0, 2'b01);
        check32("br_state", 32'(if_state), 32'(IF_DROP));
        check1("br_valid", IDvalid, 1'b0);
        check32("br_old_addr", imem_addr, 32'h10);
        stale_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00);
            if (IDvalid) stale_seen = 1'b1;
        end
        check32("drop_done_state", 32'(if_state), 32'(IF_FETCH));
        check32("drop_new_addr", imem_addr, 32'h100);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00);
            if (IDvalid && IDinst == 32'd4) stale_seen = 1'b1;
        end
        check1("stale_never_seen", stale_seen, 1'b0);
        check32("br_target_inst", IDinst, 32'h40);
        check32("br_target_pc4", IDpc4, 32'h104);

        // Reset in the middle of DROP.
        bpc = 32'h200;
        step(1'b0, 2'b01);
        check32("pre_rst_state", 32'(if_state), 32'(IF_DROP));
        do_reset();
        lat = 0;
        step(1'b0, 2'b00);
        got = (fetch_q.size() > 0) ? fetch_q[0] : 32'hFFFF_FFFF;
        check32("post_rst_fetch", got, RST_PC);
        check32("post_rst_inst", IDinst, 32'd0);

        // Random traffic against the program-order model.
        do_reset();
        d0 = delivered;
        for (int i = 0; i < 600; i++) begin
            logic       s;
            logic [1:0] ps;
            if (i % 16 == 0) lat = $urandom_range(0, 3);
            bpc = $urandom;
            rpc = $urandom;
            jpc = $urandom;
            s = ($urandom_range(0, 9) < 3);
            ps = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(s, ps);
        end
        check1("random_progress", (delivered - d0) >= 20, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_if.md
Name: pipe_if

Overview:
- Instruction-fetch stage directly upstream of pipe_ID. Holds the PC and issues fetches to instruction memory over a req/ready handshake.
- Selects the next PC from the sccu pcsource encoding and drives the IF/ID pipeline register that supplies pipe_ID's inst input.
- Handles ID-stage stalls with a one-entry hold buffer. On a taken redirect it squashes the wrong-path fetch and drops the stale memory response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INST, 32'h0000_0000, encoding placed in IDinst for bubbles.

Ports:
- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset (clear).
- stall  in  1  ID stage cannot accept a new instruction; IF/ID register holds.
- pcsource  in  2  next-PC select from sccu: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
- bpc  in  32  branch target.
- rpc  in  32  register (jr) target.
- jpc  in  32  jump target.
- imem_req  out  1  fetch request, level; held until imem_ready.
- imem_addr  out  32  fetch byte address (word-aligned), equals PC.
- imem_rdata  in  32  fetched word, valid when imem_ready=1.
- imem_ready  in  1  response strobe; one cycle per accepted request.
- IDinst  out  32  instruction to pipe_ID.
- IDpc4  out  32  address of IDinst + 4.
- IDvalid  out  1  IDinst is a real instruction, not a bubble.

Behaviour:
- Reset (clrn=0, async):
  - pc=RESET_PC, state=FETCH.
  - IDinst=NOP_INST, IDpc4=0, IDvalid=0.
  - hold buffer empty, imem_req=0 during reset.
  - Reset mid-fetch abandons the request; imem is reset by the same clrn.
- redirect = (pcsource!=00) && !stall. Redirect is ignored while stall=1.
- target = mux(pcsource): bpc/rpc/jpc. pc+4 wraps modulo 2^32. pc[1:0] is always 00, so targets are used with bits [1:0] forced to 00.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc. Precedence, top row wins:
    - redirect: pc<=target; IF/ID<=bubble. If imem_ready=1 this cycle, the word is discarded and the state stays FETCH. Otherwise go to DROP.
    - imem_ready && !stall: IDinst<=imem_rdata, IDpc4<=pc+4, IDvalid<=1, pc<=pc+4, stay FETCH. Throughput is one instruction per cycle with a zero-wait memory.
    - imem_ready && stall: buffer<=imem_rdata, bufpc4<=pc+4, pc<=pc+4, go to HOLD. IF/ID holds.
    - !imem_ready && !stall: IF/ID<=bubble.
    - !imem_ready && stall: IF/ID holds.
  - HOLD: imem_req=0.
    - stall=1: everything holds.
    - stall=0 && redirect: pc<=target, buffer discarded, IF/ID<=bubble, go to FETCH.
    - stall=0, no redirect: IDinst<=buffer, IDpc4<=bufpc4, IDvalid<=1, go to FETCH.
  - DROP: imem_req=1 with the old address latched (oldaddr), so the handshake completes.
    - imem_ready=1: response discarded, go to FETCH with the new pc.
    - A further redirect in DROP updates pc only.
    - IF/ID<=bubble unless stall=1.
- Bubble means IDinst<=NOP_INST, IDvalid<=0, IDpc4 unchanged.
- No branch delay slot: the instruction after a taken redirect never reaches ID.
- imem_addr and imem_req are stable while waiting for imem_ready, and never change before the handshake completes.

Decomposition:
- Shared package pipe_pkg:
  - PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11.
  - NOP_INST value.
  - IF state encoding: FETCH, HOLD, DROP.
- One natural sub-module: npc_mux. It is a combinational 4:1 next-PC select over pc+4/bpc/rpc/jpc, reusable by sccu-driven logic. Everything else stays in pipe_if.

Test Plan:
- Reset, then zero-wait imem returning addr>>2 as data, stall=0.
  - Cycles 1..4: IDinst=0,1,2,3; IDpc4=4,8,12,16; IDvalid=1.
- 2-cycle imem latency.
  - imem_req and imem_addr stay constant across the wait.
  - IDvalid=0 bubbles between instructions.
  - No address is fetched twice.
- stall=1 for 3 cycles while word 0x1234_5678 at pc=8 returns.
  - IF/ID holds and the FSM sits in HOLD with imem_req=0.
  - The cycle after stall drops: IDinst=0x1234_5678, IDpc4=12, next fetch addr=12.
- pcsource=01, bpc=0x100 while the fetch of pc=0x10 is pending with a 3-cycle latency.
  - Next IDvalid=0, state goes to DROP, and the stale word never appears on IDinst.
  - The next fetch addr is 0x100.
- pcsource=11 with stall=1.
  - No redirect and pc unchanged.
  - When stall drops with pcsource=11, jpc=0x40: bubble, then fetch from 0x40.
- Assert clrn=0 mid-DROP.
  - Outputs immediately read RESET_PC, NOP_INST, IDvalid=0.
  - The first fetch after release is RESET_PC.
